cmac_rx_lbus_to_mfb: RTL and testbench

CMAC_RX_LBUS_TO_MFB -- requirements
Module: cmac_rx_lbus_to_mfb

---
 rtl/cmac_lbus_pkg.sv | 13 +
 rtl/cmac_rx_lbus_to_mfb_if.sv | 17 +
 rtl/cmac_lbus_marker_decode.sv | 28 ++
 rtl/cmac_rx_lbus_to_mfb.sv | 134 +++++++++++++
 tb/tb_cmac_rx_lbus_to_mfb.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cmac_lbus_pkg.sv
// cmac_lbus_pkg: shared LBUS geometry, FSM state type and end-of-frame position helper
package cmac_lbus_pkg;
  localparam int SEGMENTS   = 4;
  localparam int SEG_WIDTH  = 128;
  localparam int MTY_WIDTH  = 4;
  localparam int BLOCK_SIZE = 8;
  localparam int DATA_WIDTH = SEGMENTS * SEG_WIDTH;
  typedef enum logic {IDLE, FRAME} state_t;
  // last valid byte of segment e: 16e + 15 - mty
  function automatic logic [5:0] eof_pos(input logic [1:0] e, input logic [MTY_WIDTH-1:0] mty);
    return {e, 4'hF} - {2'b00, mty};
  endfunction
endpackage

// File: rtl/cmac_rx_lbus_to_mfb_if.sv
// cmac_rx_lbus_to_mfb_if: LBUS receive side and MFB transmit side bundled for the converter
interface cmac_rx_lbus_to_mfb_if import cmac_lbus_pkg::*; #(parameter int CNT_WIDTH = 32);
  logic [DATA_WIDTH-1:0]          lbus_data;
  logic [SEGMENTS-1:0]            lbus_ena, lbus_sop, lbus_eop, lbus_err;
  logic [SEGMENTS*MTY_WIDTH-1:0]  lbus_mty;
  logic [DATA_WIDTH-1:0]          mfb_data;
  logic                           mfb_sof, mfb_eof, mfb_src_rdy, mfb_meta;
  logic [2:0]                     mfb_sof_pos;
  logic [5:0]                     mfb_eof_pos;
  logic [CNT_WIDTH-1:0]           cnt_frames, cnt_errors, cnt_viol;
  modport master (output lbus_data, lbus_ena, lbus_sop, lbus_eop, lbus_err, lbus_mty,
                  input mfb_data, mfb_sof, mfb_eof, mfb_src_rdy, mfb_meta, mfb_sof_pos, mfb_eof_pos,
                  cnt_frames, cnt_errors, cnt_viol);
  modport slave (input lbus_data, lbus_ena, lbus_sop, lbus_eop, lbus_err, lbus_mty,
                 output mfb_data, mfb_sof, mfb_eof, mfb_src_rdy, mfb_meta, mfb_sof_pos, mfb_eof_pos,
                 cnt_frames, cnt_errors, cnt_viol);
endinterface

// File: rtl/cmac_lbus_marker_decode.sv
// cmac_lbus_marker_decode: locates and counts SOP/EOP markers in enabled segments, checks ENA shape
module cmac_lbus_marker_decode import cmac_lbus_pkg::*; (
  input  logic [SEGMENTS-1:0] ena_i,
  input  logic [SEGMENTS-1:0] sop_i,
  input  logic [SEGMENTS-1:0] eop_i,
  output logic [1:0]          sop_idx_o,
  output logic [1:0]          eop_idx_o,
  output logic [2:0]          sop_cnt_o,
  output logic [2:0]          eop_cnt_o,
  output logic                ena_ok_o
);
  logic [SEGMENTS-1:0] ena_inc;
  assign ena_inc  = ena_i + SEGMENTS'(1);
  assign ena_ok_o = (ena_i & ena_inc) == '0;
  // scanning downwards leaves the lowest marked segment as the index
  always_comb begin
    sop_idx_o = '0;
    eop_idx_o = '0;
    sop_cnt_o = '0;
    eop_cnt_o = '0;
    for (int i = SEGMENTS - 1; i >= 0; i--) begin
      sop_idx_o = (ena_i[i] && sop_i[i]) ? 2'(i) : sop_idx_o;
      eop_idx_o = (ena_i[i] && eop_i[i]) ? 2'(i) : eop_idx_o;
      sop_cnt_o = sop_cnt_o + 3'(ena_i[i] && sop_i[i]);
      eop_cnt_o = eop_cnt_o + 3'(ena_i[i] && eop_i[i]);
    end
  end
endmodule

// File: rtl/cmac_rx_lbus_to_mfb.sv
// cmac_rx_lbus_to_mfb: converts CMAC RX LBUS words to single-region MFB words with frame checks and counters
module cmac_rx_lbus_to_mfb import cmac_lbus_pkg::*; #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [DATA_WIDTH-1:0]         RX_LBUS_DATA,
  input  logic [SEGMENTS-1:0]           RX_LBUS_ENA,
  input  logic [SEGMENTS-1:0]           RX_LBUS_SOP,
  input  logic [SEGMENTS-1:0]           RX_LBUS_EOP,
  input  logic [SEGMENTS-1:0]           RX_LBUS_ERR,
  input  logic [SEGMENTS*MTY_WIDTH-1:0] RX_LBUS_MTY,
  output logic [DATA_WIDTH-1:0]         TX_MFB_DATA,
  output logic                          TX_MFB_SOF,
  output logic                          TX_MFB_EOF,
  output logic                          TX_MFB_SRC_RDY,
  output logic [2:0]                    TX_MFB_SOF_POS,
  output logic [5:0]                    TX_MFB_EOF_POS,
  output logic                          TX_MFB_META,
  output logic [CNT_WIDTH-1:0]          CNT_FRAMES,
  output logic [CNT_WIDTH-1:0]          CNT_ERRORS,
  output logic [CNT_WIDTH-1:0]          CNT_VIOL
);
  localparam int ITEMS = SEG_WIDTH / 8;
  state_t               state_q, state_d;
  logic                 sticky_q, sticky_d;
  logic                 rdy_q, rdy_d, sof_q, sof_d, eof_q, eof_d, meta_q, meta_d, viol_d;
  logic [2:0]           sof_pos_q, sof_pos_d;
  logic [5:0]           eof_pos_q, eof_pos_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0] frames_q, frames_d, errors_q, errors_d, viol_q, viol_cnt_d;
  logic [1:0]           sop_idx, eop_idx;
  logic [2:0]           sop_cnt, eop_cnt;
  logic                 ena_ok, sop_any, eop_any, idle_ok, frame_ok, err_e;
  logic [MTY_WIDTH-1:0] mty_e;

  cmac_lbus_marker_decode u_dec (
    .ena_i(RX_LBUS_ENA), .sop_i(RX_LBUS_SOP), .eop_i(RX_LBUS_EOP),
    .sop_idx_o(sop_idx), .eop_idx_o(eop_idx), .sop_cnt_o(sop_cnt), .eop_cnt_o(eop_cnt),
    .ena_ok_o(ena_ok)
  );

  assign sop_any  = sop_cnt != 3'd0;
  assign eop_any  = eop_cnt != 3'd0;
  assign err_e    = RX_LBUS_ERR[eop_idx];
  assign mty_e    = RX_LBUS_MTY[MTY_WIDTH*eop_idx +: MTY_WIDTH];
  assign idle_ok  = ena_ok && sop_cnt == 3'd1 && (eop_cnt == 3'd0 || (eop_cnt == 3'd1 && eop_idx >= sop_idx));
  // inside a frame a new SOP may only follow the closing EOP; words without EOP must be full
  assign frame_ok = ena_ok && sop_cnt <= 3'd1 &&
                    (eop_cnt == 3'd1 ? (!sop_any || sop_idx > eop_idx) : (eop_cnt == 3'd0 && !sop_any && &RX_LBUS_ENA));

  always_comb begin
    state_d   = state_q;
    sticky_d  = sticky_q;
    rdy_d     = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    meta_d    = 1'b0;
    viol_d    = 1'b0;
    sof_pos_d = '0;
    eof_pos_d = '0;
    if (RX_LBUS_ENA != '0) begin
      if ((state_q == IDLE) ? idle_ok : frame_ok) begin
        rdy_d     = 1'b1;
        sof_d     = sop_any;
        sof_pos_d = sop_any ? {sop_idx, 1'b0} : 3'd0;
        eof_d     = eop_any;
        eof_pos_d = eop_any ? eof_pos(eop_idx, mty_e) : 6'd0;
        meta_d    = eop_any && (err_e || sticky_q);
        state_d   = (eop_any && !(state_q == FRAME && sop_any)) ? IDLE : FRAME;
        sticky_d  = eop_any ? 1'b0 : sticky_q | (|(RX_LBUS_ERR & RX_LBUS_ENA));
      end else begin
        viol_d    = 1'b1;
        rdy_d     = state_q == FRAME;
        eof_d     = state_q == FRAME;
        meta_d    = state_q == FRAME;
        eof_pos_d = (state_q == FRAME) ? 6'd63 : 6'd0;
        state_d   = IDLE;
        sticky_d  = 1'b0;
      end
    end
  end

  always_comb begin
    data_d = '0;
    for (int i = 0; i < SEGMENTS*ITEMS; i++)
      data_d[8*i +: 8] = RX_LBUS_DATA[SEG_WIDTH*(i/ITEMS) + SEG_WIDTH-1 - 8*(i%ITEMS) -: 8];
  end

  assign frames_d   = frames_q + CNT_WIDTH'(eof_d && !meta_d && !(&frames_q));
  assign errors_d   = errors_q + CNT_WIDTH'(eof_d && meta_d && !(&errors_q));
  assign viol_cnt_d = viol_q + CNT_WIDTH'(viol_d && !(&viol_q));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      sticky_q  <= 1'b0;
      rdy_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      meta_q    <= 1'b0;
      sof_pos_q <= '0;
      eof_pos_q <= '0;
      frames_q  <= '0;
      errors_q  <= '0;
      viol_q    <= '0;
    end else begin
      state_q   <= state_d;
      sticky_q  <= sticky_d;
      rdy_q     <= rdy_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      meta_q    <= meta_d;
      sof_pos_q <= sof_pos_d;
      eof_pos_q <= eof_pos_d;
      frames_q  <= frames_d;
      errors_q  <= errors_d;
      viol_q    <= viol_cnt_d;
    end
  end

  always_ff @(posedge CLK) data_q <= data_d;

  assign TX_MFB_DATA    = data_q;
  assign TX_MFB_SOF     = sof_q;
  assign TX_MFB_EOF     = eof_q;
  assign TX_MFB_SRC_RDY = rdy_q;
  assign TX_MFB_SOF_POS = sof_pos_q;
  assign TX_MFB_EOF_POS = eof_pos_q;
  assign TX_MFB_META    = meta_q;
  assign CNT_FRAMES     = frames_q;
  assign CNT_ERRORS     = errors_q;
  assign CNT_VIOL       = viol_q;
endmodule

// File: tb/tb_cmac_rx_lbus_to_mfb.sv
// tb_cmac_rx_lbus_to_mfb: random and directed LBUS traffic against a queue-based frame model with a scoreboard
module tb_cmac_rx_lbus_to_mfb;
  import cmac_lbus_pkg::*;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    bit rdy, sof, eof, meta;
    bit [2:0] sofp;
    bit [5:0] eofp;
    logic [511:0] data;
    int fr, er, vi;
  } exp_t;
  typedef struct { bit sop, eop, err; logic [3:0] mty; } seg_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  cmac_rx_lbus_to_mfb_if #(.CNT_WIDTH(CW)) bus();

  cmac_rx_lbus_to_mfb #(.CNT_WIDTH(CW)) dut (
    .CLK(clk), .RST_N(rst_n),
    .RX_LBUS_DATA(bus.lbus_data), .RX_LBUS_ENA(bus.lbus_ena), .RX_LBUS_SOP(bus.lbus_sop),
    .RX_LBUS_EOP(bus.lbus_eop), .RX_LBUS_ERR(bus.lbus_err), .RX_LBUS_MTY(bus.lbus_mty),
    .TX_MFB_DATA(bus.mfb_data), .TX_MFB_SOF(bus.mfb_sof), .TX_MFB_EOF(bus.mfb_eof),
    .TX_MFB_SRC_RDY(bus.mfb_src_rdy), .TX_MFB_SOF_POS(bus.mfb_sof_pos), .TX_MFB_EOF_POS(bus.mfb_eof_pos),
    .TX_MFB_META(bus.mfb_meta), .CNT_FRAMES(bus.cnt_frames), .CNT_ERRORS(bus.cnt_errors), .CNT_VIOL(bus.cnt_viol)
  );

  int n_chk = 0, n_pass = 0;
  exp_t q[$];
  bit m_frame = 0, m_sticky = 0;
  int m_fr = 0, m_er = 0, m_vi = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int bump(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // every 16-byte segment comes out byte-reversed in place
  function automatic logic [511:0] seg_rev(input logic [511:0] d);
    logic [511:0] r;
    for (int j = 0; j < 64; j++) r[8*j +: 8] = d[8*((j/16)*16 + 15 - j%16) +: 8];
    return r;
  endfunction

  task automatic end_frame(inout exp_t x, input int e, input logic [3:0] err, input logic [15:0] mty);
    x.eof  = 1;
    x.eofp = 6'(16*e + 15 - int'(mty[4*e +: 4]));
    x.meta = err[e] | m_sticky;
    if (x.meta) m_er = bump(m_er); else m_fr = bump(m_fr);
    m_frame = 0;
    m_sticky = 0;
  endtask

  task automatic model(input logic [3:0] ena, sop, eop, err, input logic [15:0] mty, input logic [511:0] d);
    exp_t x;
    int sops[$], eops[$];
    bit therm;
    x = '{default: 0};
    x.data = seg_rev(d);
    therm = ena inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    for (int i = 0; i < 4; i++) begin
      if (ena[i] && sop[i]) sops.push_back(i);
      if (ena[i] && eop[i]) eops.push_back(i);
    end
    if (ena != 4'h0) begin
      if (!m_frame) begin
        if (therm && sops.size() == 1 && (eops.size() == 0 || (eops.size() == 1 && eops[0] >= sops[0]))) begin
          x.rdy = 1; x.sof = 1; x.sofp = 3'(2*sops[0]);
          if (eops.size() != 0) end_frame(x, eops[0], err, mty);
          else begin m_frame = 1; m_sticky = |(err & ena); end
        end else m_vi = bump(m_vi);
      end else if (therm && eops.size() <= 1 && sops.size() <= 1 &&
                   (eops.size() == 1 ? (sops.size() == 0 || sops[0] > eops[0]) : (sops.size() == 0 && ena == 4'hF))) begin
        x.rdy = 1;
        if (eops.size() != 0) begin
          end_frame(x, eops[0], err, mty);
          if (sops.size() != 0) begin x.sof = 1; x.sofp = 3'(2*sops[0]); m_frame = 1; end
        end else m_sticky = m_sticky | (|(err & ena));
      end else begin
        x.rdy = 1; x.eof = 1; x.eofp = 63; x.meta = 1;
        m_vi = bump(m_vi); m_er = bump(m_er); m_frame = 0; m_sticky = 0;
      end
    end
    x.fr = m_fr; x.er = m_er; x.vi = m_vi;
    q.push_back(x);
  endtask

  task automatic drive(input logic [3:0] ena, sop, eop, err, input logic [15:0] mty);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
    @(negedge clk);
    bus.lbus_data = d; bus.lbus_ena = ena; bus.lbus_sop = sop;
    bus.lbus_eop = eop; bus.lbus_err = err; bus.lbus_mty = mty;
    model(ena, sop, eop, err, mty, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, bus.mfb_src_rdy, 0);
    chk({tag, "_sof"}, bus.mfb_sof, 0);
    chk({tag, "_eof"}, bus.mfb_eof, 0);
    chk({tag, "_meta"}, bus.mfb_meta, 0);
    chk({tag, "_sofpos"}, bus.mfb_sof_pos, 0);
    chk({tag, "_eofpos"}, bus.mfb_eof_pos, 0);
    chk({tag, "_frames"}, bus.cnt_frames, 0);
    chk({tag, "_errors"}, bus.cnt_errors, 0);
    chk({tag, "_viol"}, bus.cnt_viol, 0);
  endtask

  // reset lands between clock edges so its effect is observed without any edge
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    bus.lbus_ena = 4'h0;
    rst_n = 1'b0;
    m_frame = 0; m_sticky = 0; m_fr = 0; m_er = 0; m_vi = 0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_words(input int n);
    logic [3:0] ena;
    for (int k = 0; k < n; k++) begin
      int r = $urandom_range(0, 9);
      ena = (r == 0) ? 4'h0 : (r == 1) ? 4'($urandom) : (r < 4) ? 4'((1 << $urandom_range(1, 3)) - 1) : 4'hF;
      drive(ena, 4'($urandom & $urandom), 4'($urandom & $urandom), 4'($urandom & $urandom), 16'($urandom));
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic send_frames(input int nf);
    seg_t sq[$];
    for (int f = 0; f < nf; f++) begin
      int len = $urandom_range(49, 400);
      int ns = (len + 15) / 16;
      bit fe = $urandom_range(0, 3) == 0;
      for (int k = 0; k < ns; k++)
        sq.push_back('{sop: k == 0, eop: k == ns-1, err: (k == ns-1) && fe, mty: (k == ns-1) ? 4'(16*ns - len) : 4'd0});
    end
    while (sq.size() != 0) begin
      logic [3:0] ena = '0, sop = '0, eop = '0, err = '0;
      logic [15:0] mty = '0;
      for (int s = 0; s < 4 && sq.size() != 0; s++) begin
        seg_t g = sq.pop_front();
        ena[s] = 1; sop[s] = g.sop; eop[s] = g.eop; err[s] = g.err; mty[4*s +: 4] = g.mty;
      end
      drive(ena, sop, eop, err, mty);
      if ($urandom_range(0, 4) == 0) drive(0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("src_rdy", bus.mfb_src_rdy, x.rdy);
        if (x.rdy) begin
          chk("sof", bus.mfb_sof, x.sof);
          chk("eof", bus.mfb_eof, x.eof);
          if (x.sof) chk("sof_pos", bus.mfb_sof_pos, x.sofp);
          if (x.eof) begin
            chk("eof_pos", bus.mfb_eof_pos, x.eofp);
            chk("meta", bus.mfb_meta, x.meta);
          end
          chk("data", bus.mfb_data, x.data);
        end
        chk("cnt_frames", bus.cnt_frames, x.fr);
        chk("cnt_errors", bus.cnt_errors, x.er);
        chk("cnt_viol", bus.cnt_viol, x.vi);
      end else if (rst_n && bus.mfb_src_rdy) chk("spurious_rdy", bus.mfb_src_rdy, 0);
    end
  end

  initial begin
    bus.lbus_data = '0; bus.lbus_ena = '0; bus.lbus_sop = '0;
    bus.lbus_eop = '0; bus.lbus_err = '0; bus.lbus_mty = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    rst_n = 1'b1;
    drive(4'hF, 4'h1, 4'h0, 4'h0, 16'h0);
    drive(4'hF, 4'h0, 4'h8, 4'h0, 16'h0);
    drive(4'hF, 4'h1, 4'h8, 4'h0, 16'h4000);
    drive(4'hF, 4'h1, 4'h0, 4'h0, 16'h0);
    drive(0, 0, 0, 0, 0);
    drive(4'hF, 4'h4, 4'h2, 4'h0, 16'h0060);
    drive(4'h3, 4'h0, 4'h2, 4'h0, 16'h0030);
    drive(4'hF, 4'h1, 4'h0, 4'h0, 16'h0);
    drive(4'hF, 4'h0, 4'h8, 4'h8, 16'h0);
    drive(4'hF, 4'h3, 4'h0, 4'h0, 16'h0);
    drive(4'hF, 4'h1, 4'h0, 4'h0, 16'h0);
    drive(4'hF, 4'h3, 4'h0, 4'h0, 16'h0);
    drive(4'h5, 4'h1, 4'h0, 4'h0, 16'h0);
    drive(4'hF, 4'h1, 4'h0, 4'h0, 16'h0);
    drive(4'h7, 4'h0, 4'h0, 4'h0, 16'h0);
    drive(4'hF, 4'h1, 4'h0, 4'h0, 16'h0);
    do_reset("async");
    drive(4'hF, 4'h0, 4'h8, 4'h0, 16'h0);
    drive(0, 0, 0, 0, 0);
    rand_words(400);
    do_reset("mid");
    send_frames(60);
    begin
      int w = 0;
      while (q.size() != 0 && w < 100) begin @(posedge clk); w++; end
    end
    chk("drain", q.size(), 0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
